// File: rtl/apb_sched_pkg.sv
// apb_sched_pkg: FSM state type and bus geometry shared by the APB scheduler files
package apb_sched_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int SEL_BIT = 6;
endpackage

// File: rtl/apb_rr_arb2.sv
// apb_rr_arb2: two-way round-robin arbiter; pointer flips away from each winner
module apb_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic ptr;
  // a lone requester wins outright; on a tie ptr=1 favours requester 1
  always_comb gnt = (&req) ? (ptr ? 2'b10 : 2'b01) : req;
  // after each grant the loser gets the next tie
  always_ff @(posedge clk)
    if (rst) ptr <= 1'b0;
    else if (adv) ptr <= gnt[0];
endmodule

// File: rtl/apb_bus_scheduler.sv
// apb_bus_scheduler: two-requester round-robin APB master; APB_TIMEOUT_EN adds an ACCESS timeout abort
module apb_bus_scheduler
  import apb_sched_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_grant,
  output logic [1:0]          req_done,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSELECT1,
  output logic                PSELECT2,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);
  state_t state, state_d;
  logic owner, win, ok, abort, finish, start;
  logic [1:0] elig, gnt;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  apb_rr_arb2 u_arb (.clk(PCLK), .rst(PRESET), .req(elig), .adv(start), .gnt(gnt));
  // the in-flight owner is masked so it cannot win again before its done
  always_comb begin
    elig = (state == IDLE) ? req_valid : req_valid & ~(owner ? 2'b10 : 2'b01);
    ok = state == ACCESS && PREADY;
    finish = ok || abort;
    start = |elig && (state == IDLE || ok);
    win = gnt[1];
    win_addr = win ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    win_wdata = win ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
  end
  // new grant goes to SETUP, SETUP always enters ACCESS, ACCESS holds until it finishes
  always_comb begin
    state_d = start ? SETUP : (state == SETUP || (state == ACCESS && !finish)) ? ACCESS : IDLE;
  end
  // state register
  always_ff @(posedge PCLK)
    if (PRESET) state <= IDLE;
    else state <= state_d;
  // registered APB drive and requester handshake
  always_ff @(posedge PCLK)
    if (PRESET) begin
      owner <= 1'b0;
      req_grant <= '0;
      req_done <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      PSELECT1 <= 1'b0;
      PSELECT2 <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE <= 1'b0;
      PADDR <= '0;
      PWDATA <= '0;
    end else begin
      req_grant <= start ? gnt : 2'b00;
      req_done <= finish ? (owner ? 2'b10 : 2'b01) : 2'b00;
      PENABLE <= state_d == ACCESS;
      if (start) begin
        owner <= win;
        PWRITE <= req_write[win];
        PADDR <= win_addr;
        PWDATA <= win_wdata;
        PSELECT1 <= win_addr[SEL_BIT];
        PSELECT2 <= !win_addr[SEL_BIT];
      end else if (state_d == IDLE) begin
        PSELECT1 <= 1'b0;
        PSELECT2 <= 1'b0;
      end
      if (finish) begin
        rsp_rdata <= (ok && !PWRITE) ? PRDATA : '0;
        rsp_err <= ok ? PSLVERR : 1'b1;
      end
    end
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] cnt;
  // counts ACCESS cycles of the current transfer, restarting at each SETUP
  always_ff @(posedge PCLK)
    if (PRESET || state == SETUP) cnt <= '0;
    else if (state == ACCESS) cnt <= cnt + 1'b1;
  assign abort = state == ACCESS && !PREADY && cnt == LAST;
`else
  assign abort = 1'b0;
`endif
endmodule

// File: tb/tb_apb_bus_scheduler.sv
// tb_apb_bus_scheduler: randomized scoreboard bench with a transaction-level arbitration model
module tb_apb_bus_scheduler;
  typedef struct {
    bit       wr;
    bit [6:0] addr;
    bit [7:0] wdata;
  } req_t;
  typedef struct {
    bit       rid;
    bit       wr;
    bit [6:0] addr;
    bit [7:0] wdata;
    bit [7:0] rdata;
    bit       err;
    int       waits;
    int       gap;
  } exp_t;

  logic clk = 0, rst = 1;
  logic [1:0] req_valid = 0, req_write = 0;
  logic [13:0] req_addr = 0;
  logic [15:0] req_wdata = 0;
  logic [1:0] req_grant, req_done;
  logic [7:0] rsp_rdata, PRDATA, PWDATA;
  logic rsp_err, PSELECT1, PSELECT2, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [6:0] PADDR;

  apb_bus_scheduler dut (
    .PCLK(clk), .PRESET(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_grant(req_grant), .req_done(req_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSELECT1(PSELECT1), .PSELECT2(PSELECT2),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  bit mon_en = 0, m_rr = 0;
  req_t rq0[$], rq1[$];
  exp_t gq[$], dq[$];

  function automatic int waits_of(logic [6:0] a);
    return 2 * int'(a[1]) + int'(a[2]);
  endfunction
  function automatic logic [7:0] rd_of(logic [6:0] a);
    return {1'b0, a} ^ 8'h05;
  endfunction
  function automatic logic err_of(logic [6:0] a);
    return a[2:0] == 3'b101;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
  endtask

  function automatic void present();
    req_valid[0] = rq0.size() != 0;
    req_valid[1] = rq1.size() != 0;
    if (rq0.size() != 0) begin
      req_write[0] = rq0[0].wr;
      req_addr[0 +: 7] = rq0[0].addr;
      req_wdata[0 +: 8] = rq0[0].wdata;
    end
    if (rq1.size() != 0) begin
      req_write[1] = rq1[0].wr;
      req_addr[7 +: 7] = rq1[0].addr;
      req_wdata[8 +: 8] = rq1[0].wdata;
    end
  endfunction

  function automatic req_t rnd_req();
    req_t r;
    r.wr = 1'($urandom);
    r.addr = 7'($urandom);
    r.wdata = 8'($urandom);
    return r;
  endfunction

  // model: ties follow a pointer that flips after every grant; a requester alone keeps the bus
  task automatic run_batch();
    req_t a[$], b[$], r;
    exp_t e;
    bit w, prev, first;
    int guard;
    a = rq0;
    b = rq1;
    first = 1;
    prev = 0;
    while (a.size() != 0 || b.size() != 0) begin
      w = (a.size() != 0 && b.size() != 0) ? m_rr : (a.size() == 0);
      r = w ? b.pop_front() : a.pop_front();
      e.rid = w;
      e.wr = r.wr;
      e.addr = r.addr;
      e.wdata = r.wdata;
      e.rdata = r.wr ? 8'h00 : rd_of(r.addr);
      e.err = err_of(r.addr);
      e.waits = waits_of(r.addr);
      e.gap = first ? -1 : (w != prev ? 0 : 1);
      first = 0;
      prev = w;
      m_rr = !w;
      gq.push_back(e);
      dq.push_back(e);
    end
    present();
    guard = 0;
    while ((rq0.size() != 0 || rq1.size() != 0 || dq.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (req_grant[0] && rq0.size() != 0) void'(rq0.pop_front());
      if (req_grant[1] && rq1.size() != 0) void'(rq1.pop_front());
      present();
    end
    if (guard >= 3000) begin
      chk("batch_timeout", 32'(dq.size()), 0);
      rq0.delete();
      rq1.delete();
      gq.delete();
      dq.delete();
      present();
    end
  endtask

  // slave pair: wait states, read data and error are fixed functions of the address
  initial begin : slave
    int wc;
    wc = 0;
    PREADY = 0;
    PRDATA = 0;
    PSLVERR = 0;
    forever begin
      @(negedge clk);
      if (PENABLE && !rst) begin
        PREADY = wc == waits_of(PADDR);
        wc++;
      end else begin
        PREADY = 0;
        wc = 0;
      end
      PRDATA = PREADY ? rd_of(PADDR) : 8'($urandom);
      PSLVERR = PREADY ? err_of(PADDR) : 1'($urandom);
    end
  end

  // monitor: pops expected grants and completions as the DUT presents them
  initial begin : monitor
    exp_t e, cur;
    int gcyc, last_done;
    gcyc = 0;
    last_done = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        if (req_done != 0) begin
          if (dq.size() == 0) chk("done_unexpected", 32'(req_done), 0);
          else begin
            e = dq.pop_front();
            chk("done_rid", 32'(req_done), e.rid ? 2 : 1);
            chk("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("grant_to_done", 32'(cyc - gcyc), 32'(2 + e.waits));
            last_done = cyc;
          end
        end
        if (req_grant != 0) begin
          if (gq.size() == 0) chk("grant_unexpected", 32'(req_grant), 0);
          else begin
            e = gq.pop_front();
            chk("grant_rid", 32'(req_grant), e.rid ? 2 : 1);
            chk("setup_bus", {18'd0, PSELECT1, PSELECT2, PENABLE, PWRITE, PADDR, PWDATA},
                {18'd0, e.addr[6], !e.addr[6], 1'b0, e.wr, e.addr, e.wdata});
            if (e.gap >= 0) chk("grant_gap", 32'(cyc - last_done), 32'(e.gap));
            cur = e;
            gcyc = cyc;
          end
        end
        if (PENABLE)
          chk("access_bus", {19'd0, PSELECT1, PSELECT2, PWRITE, PADDR, PWDATA},
              {19'd0, cur.addr[6], !cur.addr[6], cur.wr, cur.addr, cur.wdata});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    req_t r;
    int guard;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_grant, req_done, rsp_rdata, rsp_err, PSELECT1, PSELECT2, PENABLE,
        PWRITE, PADDR, PWDATA}, 0);
    rst = 0;
    mon_en = 1;
    @(negedge clk);
    r = '{wr: 1, addr: 7'h41, wdata: 8'h05};
    rq0.push_back(r);
    run_batch();
    r = '{wr: 0, addr: 7'h03, wdata: 8'h00};
    rq1.push_back(r);
    run_batch();
    r = '{wr: 0, addr: 7'h45, wdata: 8'h00};
    rq0.push_back(r);
    r = '{wr: 0, addr: 7'h03, wdata: 8'h00};
    rq1.push_back(r);
    run_batch();
    for (int i = 0; i < 2; i++) begin
      rq0.push_back(rnd_req());
      rq1.push_back(rnd_req());
    end
    run_batch();
    for (int b = 0; b < 12; b++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) rq0.push_back(rnd_req());
      for (int i = 0; i < int'($urandom_range(0, 4)); i++) rq1.push_back(rnd_req());
      run_batch();
    end
    mon_en = 0;
    @(negedge clk);
    r = '{wr: 0, addr: 7'h16, wdata: 8'h00};
    rq0.push_back(r);
    present();
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!PENABLE && guard < 20);
    chk("reached_access", 32'(PENABLE), 1);
    rst = 1;
    rq0.delete();
    present();
    @(negedge clk);
    chk("reset_mid_access", {req_grant, req_done, rsp_rdata, rsp_err, PSELECT1, PSELECT2, PENABLE,
        PWRITE, PADDR, PWDATA}, 0);
    rst = 0;
    m_rr = 0;
    gq.delete();
    dq.delete();
    @(negedge clk);
    chk("no_done_after_reset", 32'(req_done), 0);
    mon_en = 1;
    rq0.push_back(rnd_req());
    rq1.push_back(rnd_req());
    run_batch();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_bus_scheduler.md
Name: apb_bus_scheduler

Overview:
Two-requester APB bus scheduler. Round-robin arbitrates between two local requesters (e.g. config engine and test sequencer). Sequences the granted transfer through the APB IDLE/SETUP/ACCESS protocol and decodes PADDR[6] into PSELECT1 (Slave1) and PSELECT2 (Slave2). Sits between the requesters and the shared APB bus, in front of Slave1 and Slave2.

Parameters:
ADDR_W, 7, APB address width; bit ADDR_W-1 is the slave-select bit.
DATA_W, 8, APB read/write data width.
TIMEOUT_CYC, 16, ACCESS cycles without PREADY before abort (used only with the optional feature).

Ports:
PCLK  in  1  bus clock; all logic on the rising edge.
PRESET  in  1  reset; synchronous, active-high.
req_valid  in  2  per-requester request; held high until the matching req_grant bit pulses.
req_write  in  2  per-requester direction; 1 = write.
req_addr  in  2*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
req_wdata  in  2*DATA_W  packed write data, same packing as req_addr.
req_grant  out  2  one-cycle pulse; request fields latched.
req_done  out  2  one-cycle pulse; transfer complete, rsp_* valid.
rsp_rdata  out  DATA_W  read data; held until the next done.
rsp_err  out  1  PSLVERR (or timeout) of the completed transfer.
PSELECT1  out  1  Slave1 select (PADDR[6]=1).
PSELECT2  out  1  Slave2 select (PADDR[6]=0).
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PADDR  out  ADDR_W  APB address.
PWDATA  out  DATA_W  APB write data.
PRDATA  in  DATA_W  muxed slave read data.
PREADY  in  1  muxed slave ready.
PSLVERR  in  1  slave error.

Behaviour:
- Reset: every output is 0, FSM = IDLE, RR pointer = requester 0. Reset mid-transfer drops the transfer: no req_done, PSEL and PENABLE low on the next cycle.
- FSM states: IDLE, SETUP, ACCESS. All outputs are registered.
- IDLE: if any req_valid is sampled at edge k, the scheduler does the following.
  - Arbitrates and latches write/addr/wdata of the winner.
  - Drives req_grant[winner]=1, PSELx=1, PENABLE=0 and PADDR/PWRITE/PWDATA during cycle k+1.
  - Moves to SETUP.
- SETUP: lasts exactly one cycle, then ACCESS with PENABLE=1. PADDR, PWRITE, PWDATA and PSELx stay stable.
- ACCESS: holds until PREADY=1 is sampled. At that edge:
  - req_done[winner] pulses next cycle.
  - rsp_rdata <= PRDATA for a read, or 0 for a write.
  - rsp_err <= PSLVERR.
  - PENABLE drops.
- After ACCESS, if any req_valid is high at that same edge, the scheduler arbitrates and goes straight to SETUP (back-to-back; PSEL may stay high, PENABLE low for one cycle). Otherwise it goes to IDLE with PSEL low.
- Minimum transfer: grant at cycle k+1, PENABLE at k+2, done at k+3 with zero wait states. Each wait state adds 1 cycle.
- Arbitration:
  - Single requester wins.
  - Both valid: the requester the RR pointer designates wins.
  - The pointer moves to the other requester after each grant.
- A requester's valid is ignored while it is already granted and not yet done. There is one outstanding transfer per requester.
- Exactly one of PSELECT1/PSELECT2 is high whenever not in IDLE. Both are low in IDLE.
- PSLVERR is sampled only when PENABLE=1 and PREADY=1; other values are ignored.

Optional Feature:
APB_TIMEOUT_EN:
- Defined: a counter runs in ACCESS. If PREADY is still low after TIMEOUT_CYC ACCESS cycles, the transfer aborts:
  - PSEL and PENABLE drop next cycle.
  - req_done pulses with rsp_err=1 and rsp_rdata=0.
  - FSM goes to IDLE.
  - The counter clears on every SETUP.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Decomposition:
- Package apb_sched_pkg holds:
  - the state enum typedef (IDLE/SETUP/ACCESS);
  - ADDR_W/DATA_W defaults;
  - the slave-select bit index constant (6).
- One sub-module, apb_rr_arb2: a 2-way round-robin arbiter with pointer register, advance input and one-hot grant output.
- The FSM and APB drive stay in the top.

Test Plan:
- Req0 writes 0x05 to addr 0x41, PREADY tied 1 -> PSELECT1=1, PENABLE one cycle, PWDATA=0x05, req_done[0] pulses 3 cycles after valid, rsp_err=0.
- Req1 reads addr 0x03, Slave2 returns 0x06 after 2 wait states -> PSELECT2 only, ACCESS lasts 3 cycles, rsp_rdata=0x06 on req_done[1].
- Both requesters valid continuously, 4 transfers -> grants alternate 0,1,0,1; back-to-back SETUP with no IDLE cycle between transfers.
- PSLVERR=1 with PREADY on a read of 0x45 -> rsp_err=1 with req_done; the next transfer has rsp_err=0.
- PRESET asserted during ACCESS -> all outputs 0 next cycle, no req_done; a new request after reset gets requester 0 priority.
- With APB_TIMEOUT_EN, PREADY stuck 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0, FSM back in IDLE.
